// File: rtl/cpu_seq.sv
`default_nettype none
// ============================================================================
// Module   : cpu_seq
// Purpose  : Sequential half of the 8-bit CPU: PC, A/B/C, carry, IR, output
//            latch and retire counter, with a req/ack instruction fetch.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_seq #(
    parameter logic [3:0] JMP_OP = 4'b1111,
    parameter logic [3:0] JNC_OP = 4'b1110,
    parameter logic [3:0] OUT_OP = 4'b1001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [11:0] imem_data,
    output logic [3:0]  comb_op,
    output logic [7:0]  comb_a,
    output logic [7:0]  comb_b,
    output logic [7:0]  comb_c,
    output logic [7:0]  comb_d,
    output logic        comb_cin,
    input  logic [7:0]  comb_aout,
    input  logic [7:0]  comb_bout,
    input  logic [7:0]  comb_cout,
    input  logic [7:0]  comb_dout,
    input  logic        comb_carry,
    output logic [7:0]  out_port,
    output logic        busy,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [7:0]  r_c;
    logic [7:0]  r_out;
    logic [11:0] r_ir;
    logic        r_carry;
    logic [15:0] r_retired;

    logic [7:0]  w_pc_inc;
    logic [3:0]  w_op;
    logic [7:0]  w_imm;

    assign w_pc_inc = r_pc + 8'd1;
    assign w_op     = r_ir[11:8];
    assign w_imm    = r_ir[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= 8'd0;
            r_a       <= 8'd0;
            r_b       <= 8'd0;
            r_c       <= 8'd0;
            r_out     <= 8'd0;
            r_ir      <= 12'd0;
            r_carry   <= 1'b0;
            r_retired <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // run is deliberately not sampled here: a started fetch always completes
                    if (imem_ack) begin
                        r_ir    <= imem_data;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_retired <= r_retired + 16'd1;
                    r_state   <= run ? S_FETCH : S_IDLE;
                    if (w_op == JMP_OP) begin
                        r_pc <= w_imm;
                    end else if (w_op == JNC_OP) begin
                        r_pc <= r_carry ? w_pc_inc : w_imm;
                    end else begin
                        r_a     <= comb_aout;
                        r_b     <= comb_bout;
                        r_c     <= comb_cout;
                        r_carry <= comb_carry;
                        r_pc    <= w_pc_inc;
                        if (w_op == OUT_OP) begin
                            r_out <= comb_dout;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Decoded from state only, so reset drops the request without a clock edge
    assign imem_req  = (r_state == S_FETCH);
    assign busy      = (r_state != S_IDLE);
    assign imem_addr = r_pc;
    assign comb_op   = w_op;
    assign comb_d    = w_imm;
    assign comb_a    = r_a;
    assign comb_b    = r_b;
    assign comb_c    = r_c;
    assign comb_cin  = r_carry;
    assign out_port  = r_out;
    assign retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_seq
// Purpose  : Self-checking bench for cpu_seq with an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [11:0] imem_data = 12'd0;
    logic [3:0]  comb_op;
    logic [7:0]  comb_a, comb_b, comb_c, comb_d;
    logic        comb_cin;
    logic [7:0]  comb_aout, comb_bout, comb_cout, comb_dout;
    logic        comb_carry;
    logic [7:0]  out_port;
    logic        busy;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    // instruction-level architectural model
    logic [7:0]  m_pc, m_a, m_b, m_c, m_out;
    logic        m_cy;
    logic [15:0] m_ret;

    always #5 clk = ~clk;

    cpu_seq dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .comb_op(comb_op), .comb_a(comb_a), .comb_b(comb_b), .comb_c(comb_c),
        .comb_d(comb_d), .comb_cin(comb_cin),
        .comb_aout(comb_aout), .comb_bout(comb_bout), .comb_cout(comb_cout),
        .comb_dout(comb_dout), .comb_carry(comb_carry),
        .out_port(out_port), .busy(busy), .retired(retired)
    );

    // stand-in for the cpu_comb datapath: {carry, aout, bout, cout, dout}
    function automatic logic [32:0] dp(input logic [3:0] op, input logic [7:0] a, b, c, d,
                                       input logic cin);
        logic [8:0] s;
        logic [7:0] ao;
        logic       cy;
        s = 9'd0;
        case (op)
            4'h3:    begin ao = 8'h5A; cy = 1'b1; end
            4'h0:    begin s = {1'b0, a} + {1'b0, d} + {8'd0, cin}; ao = s[7:0]; cy = s[8]; end
            default: begin s = {1'b0, a} + {1'b0, b}; ao = s[7:0]; cy = s[8]; end
        endcase
        return {cy, ao, b ^ d, c + d, a ^ d};
    endfunction

    assign {comb_carry, comb_aout, comb_bout, comb_cout, comb_dout} =
        dp(comb_op, comb_a, comb_b, comb_c, comb_d, comb_cin);

    task automatic model_reset();
        m_pc = 8'd0; m_a = 8'd0; m_b = 8'd0; m_c = 8'd0; m_out = 8'd0; m_cy = 1'b0; m_ret = 16'd0;
    endtask

    // Executes one instruction; entered and left at a negedge with the DUT in FETCH on entry.
    task automatic run_instr(input logic [11:0] word, input int waits, input bit drop_run);
        logic [32:0] r;
        logic [3:0]  op;
        logic [7:0]  imm;
        op  = word[11:8];
        imm = word[7:0];
        total++;
        if (imem_req !== 1'b1 || busy !== 1'b1 || imem_addr !== m_pc) begin
            bad++;
            $display("FAIL fetch_start: req=%b busy=%b addr=%h required req=1 busy=1 addr=%h",
                     imem_req, busy, imem_addr, m_pc);
        end
        for (int w = 0; w < waits; w++) begin
            if (drop_run) run = 1'b0;
            imem_ack  = 1'b0;
            imem_data = 12'($urandom);
            @(negedge clk);
            total++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
                bad++;
                $display("FAIL fetch_wait: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, m_pc);
            end
        end
        imem_ack  = 1'b1;
        imem_data = word;
        @(negedge clk);
        imem_ack  = 1'b0;
        total++;
        if (imem_req !== 1'b0 || busy !== 1'b1 || comb_op !== op || comb_d !== imm ||
            comb_a !== m_a || comb_b !== m_b || comb_c !== m_c || comb_cin !== m_cy) begin
            bad++;
            $display("FAIL exec_view: req=%b busy=%b op=%h d=%h a=%h b=%h c=%h cin=%b required req=0 busy=1 op=%h d=%h a=%h b=%h c=%h cin=%b",
                     imem_req, busy, comb_op, comb_d, comb_a, comb_b, comb_c, comb_cin,
                     op, imm, m_a, m_b, m_c, m_cy);
        end
        if (op == 4'hF) begin
            m_pc = imm;
        end else if (op == 4'hE) begin
            m_pc = m_cy ? m_pc + 8'd1 : imm;
        end else begin
            r = dp(op, m_a, m_b, m_c, imm, m_cy);
            {m_cy, m_a, m_b, m_c} = r[32:8];
            if (op == 4'h9) m_out = r[7:0];
            m_pc = m_pc + 8'd1;
        end
        m_ret = m_ret + 16'd1;
        @(negedge clk);
        total++;
        if (imem_addr !== m_pc || comb_a !== m_a || comb_b !== m_b || comb_c !== m_c ||
            comb_cin !== m_cy || out_port !== m_out || retired !== m_ret ||
            imem_req !== run || busy !== run) begin
            bad++;
            $display("FAIL retire: pc=%h a=%h b=%h c=%h cy=%b out=%h ret=%0d req=%b busy=%b required pc=%h a=%h b=%h c=%h cy=%b out=%h ret=%0d req=%b busy=%b",
                     imem_addr, comb_a, comb_b, comb_c, comb_cin, out_port, retired, imem_req, busy,
                     m_pc, m_a, m_b, m_c, m_cy, m_out, m_ret, run, run);
        end
    endtask

    task automatic start_run();
        run = 1'b1;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1) begin
            bad++;
            $display("FAIL start_run: req=%b required 1", imem_req);
        end
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || imem_addr !== 8'd0 || retired !== 16'd0 ||
            out_port !== 8'd0 || comb_op !== 4'd0 || comb_a !== 8'd0 || comb_cin !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: req=%b busy=%b addr=%h ret=%0d out=%h op=%h a=%h cin=%b required all 0",
                     imem_req, busy, imem_addr, retired, out_port, comb_op, comb_a, comb_cin);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_run: req=%b busy=%b required 0 0", imem_req, busy);
        end
    endtask

    task automatic test_stream();
        start_run();
        for (int i = 0; i < 4; i++) run_instr(12'h005, 0, 1'b0);
        total++;
        if (retired !== 16'd4 || imem_addr !== 8'd4) begin
            bad++;
            $display("FAIL stream_8cyc: ret=%0d addr=%h required ret=4 addr=04", retired, imem_addr);
        end
    endtask

    task automatic test_jnc();
        run_instr(12'h311, 0, 1'b0);
        total++;
        if (comb_a !== 8'h5A || comb_cin !== 1'b1) begin
            bad++;
            $display("FAIL op3_writeback: a=%h cin=%b required a=5a cin=1", comb_a, comb_cin);
        end
        run_instr(12'hE20, 0, 1'b0);
        total++;
        if (imem_addr !== 8'h06) begin
            bad++;
            $display("FAIL jnc_carry_set: addr=%h required 06", imem_addr);
        end
        run_instr(12'h000, 0, 1'b0);  // 5A+0+1 clears carry
        run_instr(12'hE40, 0, 1'b0);
        total++;
        if (imem_addr !== 8'h40 || comb_cin !== 1'b0) begin
            bad++;
            $display("FAIL jnc_carry_clear: addr=%h cin=%b required addr=40 cin=0", imem_addr, comb_cin);
        end
    endtask

    task automatic test_jump_wrap();
        logic [7:0] a0;
        run_instr(12'hFFF, 1, 1'b0);
        a0 = comb_a;
        run_instr(12'hF80, 0, 1'b0);
        total++;
        if (imem_addr !== 8'h80 || comb_a !== a0) begin
            bad++;
            $display("FAIL jmp_at_ff: addr=%h a=%h required addr=80 a=%h", imem_addr, comb_a, a0);
        end
        run_instr(12'hFFF, 0, 1'b0);
        run_instr(12'h212, 2, 1'b0);
        total++;
        if (imem_addr !== 8'h00) begin
            bad++;
            $display("FAIL pc_wrap: addr=%h required 00", imem_addr);
        end
    endtask

    task automatic test_out();
        logic [7:0] imm;
        imm = 8'hC3 ^ m_a;
        run_instr({4'h9, imm}, 0, 1'b0);
        total++;
        if (out_port !== 8'hC3) begin
            bad++;
            $display("FAIL out_load: out=%h required c3", out_port);
        end
        run_instr(12'h2A5, 0, 1'b0);
        total++;
        if (out_port !== 8'hC3) begin
            bad++;
            $display("FAIL out_hold: out=%h required c3", out_port);
        end
    endtask

    task automatic test_run_drop();
        run_instr(12'h233, 3, 1'b1);
        @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_drop: req=%b busy=%b required 0 0", imem_req, busy);
        end
        start_run();
    endtask

    task automatic test_reset_midfetch();
        imem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || imem_addr !== 8'd0 || retired !== 16'd0 ||
            out_port !== 8'd0 || comb_a !== 8'd0 || comb_b !== 8'd0 || comb_c !== 8'd0 ||
            comb_cin !== 1'b0 || comb_op !== 4'd0 || comb_d !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: req=%b busy=%b addr=%h ret=%0d out=%h a=%h b=%h c=%h cin=%b op=%h d=%h required all 0",
                     imem_req, busy, imem_addr, retired, out_port, comb_a, comb_b, comb_c,
                     comb_cin, comb_op, comb_d);
        end
        model_reset();
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 12'h9AB;
        repeat (3) @(negedge clk);
        total++;
        if (comb_op !== 4'd0 || comb_d !== 8'd0 || imem_req !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stray_ack: op=%h d=%h req=%b busy=%b required 0", comb_op, comb_d, imem_req, busy);
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_random();
        bit drop;
        start_run();
        for (int i = 0; i < 60; i++) begin
            drop = ($urandom_range(0, 7) == 0);
            run_instr(12'($urandom), int'($urandom_range(0, 3)), drop);
            if (drop) start_run();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_jnc();
        test_jump_wrap();
        test_out();
        test_run_drop();
        test_reset_midfetch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
